// File: rtl/tap_ctrl.sv
// tap_ctrl: IEEE 1149.1-style TAP controller clocked by the system clock.
// Each clk cycle is one TAP step. The block holds the instruction register,
// the bypass register and the IDCODE register. It drives capture/shift/update
// strobes and chain selects to an external boundary-scan register (BSR), and
// muxes the serial return onto tdo.
module tap_ctrl #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1876_5001
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tms,
  input  logic                tdi,
  input  logic                bsr_tdo,
  output logic                tdo,
  output logic                tdo_en,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                select_bsr,
  output logic                extest,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                tlr
);

  localparam logic [IR_WIDTH-1:0] INSTR_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] INSTR_SAMPLE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE   = IR_WIDTH'(1);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 go_tlr;
  logic [IR_WIDTH-1:0]  ir_sr;
  logic                 bypass_reg;
  logic [31:0]          idcode_reg;
  logic                 sel_idcode;

  // Instruction decode; any code other than EXTEST/SAMPLE/IDCODE acts as BYPASS.
  assign select_bsr = (ir_out == INSTR_EXTEST) || (ir_out == INSTR_SAMPLE);
  assign extest     = (ir_out == INSTR_EXTEST);
  assign sel_idcode = (ir_out == INSTR_IDCODE);

  // TAP state transition table (next state for the sampled tms).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next = state;
    case (state)
      TLR:      state_next = tms ? TLR    : RTI;
      RTI:      state_next = tms ? SEL_DR : RTI;
      SEL_DR:   state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_next = tms ? EX1_DR : SH_DR;
      SH_DR:    state_next = tms ? EX1_DR : SH_DR;
      EX1_DR:   state_next = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_next = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_next = tms ? UPD_DR : SH_DR;
      UPD_DR:   state_next = tms ? SEL_DR : RTI;
      SEL_IR:   state_next = tms ? TLR    : CAP_IR;
      CAP_IR:   state_next = tms ? EX1_IR : SH_IR;
      SH_IR:    state_next = tms ? EX1_IR : SH_IR;
      EX1_IR:   state_next = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_next = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_next = tms ? UPD_IR : SH_IR;
      UPD_IR:   state_next = tms ? SEL_DR : RTI;
      default:  state_next = TLR;
    endcase
  end

  // Entering Test-Logic-Reset by tms is treated exactly like the reset pin.
  assign go_tlr = reset || (state_next == TLR);

  // FSM, scan registers and registered state-decode outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (go_tlr) begin
      state      <= TLR;
      ir_out     <= INSTR_IDCODE;
      ir_sr      <= IR_CAPTURE;
      bypass_reg <= 1'b0;
      idcode_reg <= IDCODE_VAL;
      tlr        <= 1'b1;
      tdo_en     <= 1'b0;
      capture_dr <= 1'b0;
      shift_dr   <= 1'b0;
      update_dr  <= 1'b0;
    end else begin
      state      <= state_next;
      tlr        <= 1'b0;
      tdo_en     <= (state_next == SH_DR) || (state_next == SH_IR);
      capture_dr <= (state_next == CAP_DR);
      shift_dr   <= (state_next == SH_DR);
      update_dr  <= (state_next == UPD_DR);
      case (state)
        CAP_IR: ir_sr  <= IR_CAPTURE;
        SH_IR:  ir_sr  <= {tdi, ir_sr[IR_WIDTH-1:1]};
        UPD_IR: ir_out <= ir_sr;
        CAP_DR: begin
          bypass_reg <= 1'b0;
          if (sel_idcode) idcode_reg <= IDCODE_VAL;
        end
        SH_DR: begin
          bypass_reg <= tdi;
          if (sel_idcode) idcode_reg <= {tdi, idcode_reg[31:1]};
        end
        default: ;
      endcase
    end
  end

  // Serial return mux, built from registered sources only (plus bsr_tdo).
  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) begin
      tdo = ir_sr[0];
    end else if (state == SH_DR) begin
      if (select_bsr)      tdo = bsr_tdo;
      else if (sel_idcode) tdo = idcode_reg[0];
      else                 tdo = bypass_reg;
    end
  end

endmodule

// File: tb/tb_tap_ctrl.sv
// tb_tap_ctrl: directed-vector bench for tap_ctrl with hand-computed expectations.
module tb_tap_ctrl;

  localparam logic [31:0] IDV = 32'h1876_5001;

  logic       clk = 1'b0;
  logic       reset, tms, tdi, bsr_tdo;
  logic       tdo, tdo_en, capture_dr, shift_dr, update_dr;
  logic       select_bsr, extest, tlr;
  logic [3:0] ir_out;

  int n_checks = 0;
  int n_pass   = 0;

  tap_ctrl #(.IR_WIDTH(4), .IDCODE_VAL(IDV)) dut (
    .clk(clk), .reset(reset), .tms(tms), .tdi(tdi), .bsr_tdo(bsr_tdo),
    .tdo(tdo), .tdo_en(tdo_en), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .select_bsr(select_bsr), .extest(extest),
    .ir_out(ir_out), .tlr(tlr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Apply tms/tdi for one TAP step; outputs are examined 1 time unit after the edge.
  task automatic tick(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge clk);
    #1;
  endtask

  // From RTI: scan an instruction in and return to RTI.
  task automatic load_ir(input logic [3:0] code);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) tick(i == 3, code[i]);
    tick(1, 0); tick(0, 0);
  endtask

  // From RTI: go to Shift-DR (through Capture-DR).
  task automatic goto_shdr();
    tick(1, 0); tick(0, 0); tick(0, 0);
  endtask

  initial begin
    logic [31:0] word;
    logic        en_all;
    logic [4:0]  byp_in;
    logic [4:0]  byp_exp;
    logic [2:0]  bsr_pat;

    reset = 1'b1; tms = 1'b0; tdi = 1'b0; bsr_tdo = 1'b0;

    // Reset state
    tick(0, 0); tick(0, 0);
    check("rst_tlr", tlr, 1);
    check("rst_ir_out", ir_out, 4'b0010);
    check("rst_outs", {tdo, tdo_en, capture_dr, shift_dr, update_dr, select_bsr, extest}, 7'b0);
    reset = 1'b0;

    // IDCODE readout: TMS=0,1,0,0 -> ShDR, 32 shifts
    tick(0, 0); tick(1, 0); tick(0, 0);
    check("capture_dr_pulse", {capture_dr, shift_dr, update_dr}, 3'b100);
    tick(0, 0);
    word = '0; en_all = 1'b1;
    for (int i = 0; i < 32; i++) begin
      word[i] = tdo;
      en_all  = en_all & tdo_en & shift_dr;
      tick(i == 31, 0);
    end
    check("idcode_value", word, IDV);
    check("idcode_tdo_en", en_all, 1);
    tick(1, 0);
    check("update_dr_pulse", {capture_dr, shift_dr, update_dr}, 3'b001);
    tick(0, 0);

    // IR scan with tdi=1111: tdo shows capture pattern 0001 LSB first
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    word = '0; en_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      word[i] = tdo;
      en_all  = en_all & tdo_en;
      tick(i == 3, 1);
    end
    check("ir_capture", word, 32'h1);
    check("ir_tdo_en", en_all, 1);
    tick(1, 0);
    check("ir_hold_in_upd", ir_out, 4'b0010);
    tick(0, 0);
    check("ir_bypass", ir_out, 4'b1111);

    // BYPASS: tdi 1,0,1,1,0 -> tdo 0,1,0,1,1
    goto_shdr();
    byp_in  = 5'b01101;   // index i is cycle i
    byp_exp = 5'b11010;
    word = '0;
    for (int i = 0; i < 5; i++) begin
      word[i] = tdo;
      tick(i == 4, byp_in[i]);
    end
    check("bypass_delay", word, {27'b0, byp_exp});
    tick(1, 0); tick(0, 0);

    // SAMPLE decode
    load_ir(4'b0001);
    check("sample_sel", {select_bsr, extest}, 2'b10);

    // EXTEST: strobes and tdo follows bsr_tdo
    load_ir(4'b0000);
    check("extest_sel", {select_bsr, extest}, 2'b11);
    tick(1, 0); tick(0, 0);
    check("ext_capture", {capture_dr, shift_dr, update_dr}, 3'b100);
    tick(0, 0);
    bsr_pat = 3'b101;
    word = '0;
    for (int i = 0; i < 3; i++) begin
      bsr_tdo = bsr_pat[i];
      #1;
      word[i] = tdo;
      check("ext_shift", {shift_dr, tdo_en}, 2'b11);
      tick(i == 2, 0);
    end
    check("ext_tdo", word, 32'b101);
    bsr_tdo = 1'b0;
    tick(1, 0);
    check("ext_update", {capture_dr, shift_dr, update_dr}, 3'b001);
    check("ext_stable", {select_bsr, extest}, 2'b11);
    tick(0, 0);

    // Five TMS=1 from ShDR reach TLR and restore IDCODE
    goto_shdr();
    for (int i = 0; i < 5; i++) tick(1, 0);
    check("tms_tlr", tlr, 1);
    check("tms_tlr_ir", ir_out, 4'b0010);

    // Reset aborts an IR shift
    tick(0, 0);
    load_ir(4'b1111);
    check("pre_abort_ir", ir_out, 4'b1111);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 0); tick(0, 0);
    reset = 1'b1;
    tick(0, 0);
    reset = 1'b0;
    check("abort_tlr", tlr, 1);
    check("abort_ir", ir_out, 4'b0010);

    // PauseDR in the middle of an IDCODE scan
    tick(0, 0);
    goto_shdr();
    word = '0;
    for (int i = 0; i < 5; i++) begin
      word[i] = tdo;
      tick(i == 4, 0);
    end
    tick(0, 0);
    for (int i = 0; i < 9; i++) tick(0, 0);
    check("pause_tdo", {tdo, tdo_en}, 2'b00);
    tick(1, 0); tick(0, 0);
    for (int i = 5; i < 10; i++) begin
      word[i] = tdo;
      tick(i == 9, 0);
    end
    check("pause_resume", word[9:0], {22'b0, IDV[9:0]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tap_ctrl.md
# tap_ctrl

IEEE 1149.1-style TAP controller that drives the boundary-scan wrapper of the Project 5 DFT top level. It decodes the serial TMS/TDI pins into the 16-state TAP FSM. It holds the 4-bit instruction register, the bypass register and the 32-bit IDCODE register. It issues capture/shift/update strobes and chain selects to the downstream boundary-scan register and muxes the serial return onto TDO. Everything runs on the single system clock; every TAP step is one `clk` cycle.

## Interface
- `IR_WIDTH`, 4: instruction register width.
- `IDCODE_VAL`, 32'h1876_5001: device ID. Bit 0 must be 1.
- `clk`  input  1  system clock. All state changes on the rising edge.
- `reset`  input  1  synchronous, active-high. Forces Test-Logic-Reset.
- `tms`  input  1  TAP mode select, sampled every cycle.
- `tdi`  input  1  serial data in.
- `bsr_tdo`  input  1  serial return from the downstream boundary-scan register.
- `tdo`  output  1  serial data out.
- `tdo_en`  output  1  high in Shift-IR or Shift-DR.
- `capture_dr`, `shift_dr`, `update_dr`  output  1 each  one-hot decode of the current state, to the BSR.
- `select_bsr`  output  1  active instruction targets the BSR (EXTEST or SAMPLE).
- `extest`  output  1  active instruction is EXTEST (BSR drives core outputs).
- `ir_out`  output  IR_WIDTH  active (updated) instruction.
- `tlr`  output  1  FSM is in Test-Logic-Reset.

## Operation
- The FSM has 16 states. Transitions are listed as next state for TMS=0 / TMS=1.
  - TLR: RTI / TLR.
  - RTI: RTI / SelDR.
  - SelDR: CapDR / SelIR.
  - CapDR: ShDR / Ex1DR.
  - ShDR: ShDR / Ex1DR.
  - Ex1DR: PauseDR / UpdDR.
  - PauseDR: PauseDR / Ex2DR.
  - Ex2DR: ShDR / UpdDR.
  - UpdDR: RTI / SelDR.
  - SelIR: CapIR / TLR.
  - CapIR through UpdIR mirror the DR column. UpdIR: RTI / SelDR.
- Five consecutive TMS=1 cycles reach TLR from any state.
- Instruction decode:
  - EXTEST = 4'b0000.
  - SAMPLE = 4'b0001.
  - IDCODE = 4'b0010.
  - BYPASS = 4'b1111.
  - Every other code behaves as BYPASS.
- IR shift register:
  - Loads 4'b0001 in CapIR.
  - In ShIR, shifts right: `tdi` enters the MSB, the LSB goes to `tdo`.
  - Copies to `ir_out` on the clock edge that leaves UpdIR.
- DR path by `ir_out`:
  - IDCODE: 32-bit shift register. Loads `IDCODE_VAL` in CapDR and shifts right in ShDR.
  - BYPASS: 1-bit register. Loads 0 in CapDR; in ShDR it takes `tdi`.
  - EXTEST/SAMPLE: the BSR is external. `tdo` = `bsr_tdo`. The block supplies only the strobes and `select_bsr`.
- `tdo` mux (combinational from registered sources):
  - ShIR: IR LSB.
  - ShDR: LSB of the selected DR, or `bsr_tdo`.
  - Otherwise 0.
- `capture_dr`/`shift_dr`/`update_dr` are asserted in the matching state regardless of instruction. The BSR qualifies them with `select_bsr`.
- Pause states hold every shift register unchanged.

## Timing
- Reset values:
  - state = TLR.
  - `ir_out` = IDCODE (4'b0010).
  - IR shift register = 4'b0001.
  - bypass register = 0.
  - IDCODE register = `IDCODE_VAL`.
  - `tdo` = 0, `tdo_en` = 0, all strobes 0, `select_bsr` = 0, `extest` = 0, `tlr` = 1.
- Entering TLR by TMS behaves exactly like reset: `ir_out` is forced to IDCODE on the edge that enters TLR.
- `reset` takes priority over `tms`. Reset asserted mid-shift aborts the shift; no update occurs and `ir_out` becomes IDCODE.
- Shift latency: the first `tdo` bit is valid in the first ShDR/ShIR cycle. It is the LSB of the captured value.
- `tdi` sampled in the final shift cycle (the cycle whose TMS=1 leads to Ex1) is still shifted in.
- BYPASS is one cycle from `tdi` to `tdo`.
- `ir_out`, `select_bsr` and `extest` change only on the edge leaving UpdIR, or on entry to TLR. They are stable throughout DR scans.

## Test plan
- Reset, then TMS=0,1,0,0 → ShDR. Shift 32 cycles with TMS=0 → `tdo` serially reproduces 32'h1876_5001, LSB first, and `tdo_en`=1 throughout.
- From RTI, TMS=1,1,0,0 → ShIR. Shift tdi=1,1,1,1 (TMS=1 on the last bit), then TMS=1,0 → `tdo` emits 1,0,0,0 (the capture pattern) and `ir_out`=4'b1111 after UpdIR.
- BYPASS loaded, ShDR, drive tdi=1,0,1,1,0 → `tdo` = 0 (captured bit), then 1,0,1,1: one-cycle delay.
- Load EXTEST and run a DR scan → `extest`=1, `select_bsr`=1, `capture_dr`/`shift_dr`/`update_dr` each pulse in their states, and `tdo` follows `bsr_tdo`.
- From ShDR, hold TMS=1 for 5 cycles → `tlr`=1 and `ir_out`=4'b0010. Separately, assert `reset` during ShIR → next cycle in TLR with `ir_out`=4'b0010 and no partial instruction applied.
- Enter PauseDR mid-IDCODE shift for 10 cycles, then Ex2DR→ShDR → `tdo` resumes with the next unshifted IDCODE bit.
